// File: rtl/cla_nibble_seq_ctrl.sv
// Sequential WIDTH-bit adder that reuses one 4-bit carry-lookahead slice,
// processing one nibble per cycle from least significant upward.

module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [IDXW+1:0]  base;
    logic [3:0]       s_sum;
    logic             s_cout;

    // Bit offset of the current nibble (idx * 4)
    assign base = {idx, 2'b00};

    cla_4bit u_slice (
        .a    (opa[base +: 4]),
        .b    (opb[base +: 4]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            opa   <= '0;
            opb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        sum   <= '0;
                        cout  <= 1'b0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: 4] <= s_sum;
                    carry          <= s_cout;
                    if (idx == IDXW'(NIB - 1)) begin
                        cout  <= s_cout;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
